// File: rtl/clock_display_mux.sv
// Four-digit multiplexed seven-segment driver for HH:MM BCD time.
// Ports: clk, rst (async active-low), hour1/hour0/min1/min0 BCD in, blank_lz, blink_en; an, seg, dp active-low out.
module clock_display_mux #(
  parameter int CLK_HZ     = 50000000,
  parameter int REFRESH_HZ = 250,
  parameter int BLANK_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SLOT_CYC = CLK_HZ / (4 * REFRESH_HZ);
  localparam int HALF     = CLK_HZ / 2;
  localparam int SCW      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int BCW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(SLOT_CYC - 1);
  localparam logic [SCW-1:0] SC_BLNK = SCW'(BLANK_CYC);
  localparam logic [BCW-1:0] BC_LAST = BCW'(HALF - 1);

  logic [SCW-1:0] sc;
  logic [1:0]     d;
  logic [BCW-1:0] bc;
  logic           phase;
  logic [1:0]     s_h1;
  logic [3:0]     s_h0;
  logic [2:0]     s_m1;
  logic [3:0]     s_m0;

  logic           sc_wrap;
  logic           load;
  logic [3:0]     val;
  logic           ok;
  logic [6:0]     seg_n;
  logic [3:0]     an_n;
  logic           dp_n;
  logic           colon_on;

  assign sc_wrap  = (sc == SC_LAST);
  assign load     = sc_wrap && (d == 2'd3);
  assign colon_on = blink_en ? phase : 1'b1;

  always_comb begin
    val = 4'd0;
    ok  = 1'b1;
    unique case (1'b1)
      (d == 2'd0): begin
        val = s_m0;
        ok  = (s_m0 <= 4'd9);
      end
      (d == 2'd1): begin
        val = {1'b0, s_m1};
        ok  = (s_m1 <= 3'd5);
      end
      (d == 2'd2): begin
        val = s_h0;
        ok  = (s_h0 <= 4'd9);
      end
      (d == 2'd3): begin
        val = {2'b00, s_h1};
        ok  = (s_h1 <= 2'd2);
      end
    endcase
  end

  always_comb begin
    seg_n = 7'b0111111;
    if (ok) begin
      case (val)
        4'd0:    seg_n = 7'b1000000;
        4'd1:    seg_n = 7'b1111001;
        4'd2:    seg_n = 7'b0100100;
        4'd3:    seg_n = 7'b0110000;
        4'd4:    seg_n = 7'b0011001;
        4'd5:    seg_n = 7'b0010010;
        4'd6:    seg_n = 7'b0000010;
        4'd7:    seg_n = 7'b1111000;
        4'd8:    seg_n = 7'b0000000;
        4'd9:    seg_n = 7'b0010000;
        default: seg_n = 7'b0111111;
      endcase
    end
    // Leading hour zero is dark but its anode still scans normally.
    if (d == 2'd3 && blank_lz && s_h1 == 2'd0)
      seg_n = 7'b1111111;
  end

  always_comb begin
    an_n = ~(4'b0001 << d);
    if (sc < SC_BLNK)
      an_n = 4'b1111;
    dp_n = !(d == 2'd2 && colon_on);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc    <= '0;
      d     <= 2'd0;
      bc    <= '0;
      phase <= 1'b1;
      s_h1  <= 2'd0;
      s_h0  <= 4'd0;
      s_m1  <= 3'd0;
      s_m0  <= 4'd0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      sc <= sc_wrap ? '0 : sc + 1'b1;
      if (sc_wrap)
        d <= d + 2'd1;
      if (bc == BC_LAST) begin
        bc    <= '0;
        phase <= ~phase;
      end else begin
        bc <= bc + 1'b1;
      end
      // Whole-frame snapshot keeps all four digits coherent.
      if (load) begin
        s_h1 <= hour1;
        s_h0 <= hour0;
        s_m1 <= min1;
        s_m0 <= min0;
      end
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule

// File: tb/tb_clock_display_mux.sv
// Directed self-checking bench for clock_display_mux.
// Small parameters: 4-cycle slots, 16-cycle frames, 32-cycle blink half-period.
module tb_clock_display_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hour1;
  logic [3:0] hour0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic       blank_lz;
  logic       blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;
  int t = -1;

  always #5 clk = ~clk;

  clock_display_mux #(
    .CLK_HZ(64),
    .REFRESH_HZ(4),
    .BLANK_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hour1(hour1),
    .hour0(hour0),
    .min1(min1),
    .min0(min0),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  // t = index of the scan state whose registered outputs are now visible.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic logic [3:0] exp_an(int tt);
    int sc;
    int d;
    sc = tt % 4;
    d  = (tt / 4) % 4;
    if (sc == 0) return 4'b1111;
    return ~(4'(4'b0001 << d));
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    hour1 = 2'd2;
    hour0 = 4'd3;
    min1 = 3'd5;
    min0 = 4'd9;
    blank_lz = 1'b1;
    blink_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111) begin
      failures++;
      $display("FAIL reset_an got=%b exp=1111", an);
    end
    checks++;
    if (seg !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_seg got=%b exp=1111111", seg);
    end
    checks++;
    if (dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_dp got=%b exp=1", dp);
    end
    @(negedge clk);
    rst = 1'b1;
    t = -1;
  endtask

  task automatic test_first_frames();
    logic [6:0] ef [8];
    logic [6:0] es;
    logic       ed;
    int d;
    ef = '{7'h40, 7'h40, 7'h40, 7'h7F, 7'h10, 7'h12, 7'h30, 7'h24};
    repeat (32) begin
      step();
      d  = (t / 4) % 4;
      es = ef[(t / 16) * 4 + d];
      ed = (d == 2) ? 1'b0 : 1'b1;
      checks++;
      if (an !== exp_an(t)) begin
        failures++;
        $display("FAIL frame_an t=%0d got=%b exp=%b", t, an, exp_an(t));
      end
      checks++;
      if (seg !== es) begin
        failures++;
        $display("FAIL frame_seg t=%0d got=%b exp=%b", t, seg, es);
      end
      checks++;
      if (dp !== ed) begin
        failures++;
        $display("FAIL frame_dp t=%0d got=%b exp=%b", t, dp, ed);
      end
    end
  endtask

  task automatic test_tearing();
    logic [6:0] es;
    while (t < 51) begin
      step();
      if (t == 33) min0 = 4'd0;
      if ((t / 4) % 4 == 0 && (t < 36 || t >= 48)) begin
        es = (t < 36) ? 7'h10 : 7'h40;
        checks++;
        if (seg !== es) begin
          failures++;
          $display("FAIL tear_seg t=%0d got=%b exp=%b", t, seg, es);
        end
        checks++;
        if (an !== exp_an(t)) begin
          failures++;
          $display("FAIL tear_an t=%0d got=%b exp=%b", t, an, exp_an(t));
        end
      end
    end
  endtask

  task automatic test_colon();
    logic colon;
    logic ed;
    int d;
    while (t < 111) begin
      step();
      d = (t / 4) % 4;
      colon = (t >= 96) ? 1'b1 : ((t / 32) % 2 == 0);
      ed = (d == 2 && colon) ? 1'b0 : 1'b1;
      checks++;
      if (dp !== ed) begin
        failures++;
        $display("FAIL colon_dp t=%0d got=%b exp=%b", t, dp, ed);
      end
      if (t == 95) blink_en = 1'b0;
    end
  endtask

  task automatic test_invalid();
    logic [6:0] ef [8];
    logic [6:0] es;
    int d;
    ef = '{7'h40, 7'h12, 7'h30, 7'h24, 7'h3F, 7'h3F, 7'h19, 7'h3F};
    min0 = 4'hC;
    min1 = 3'd6;
    hour1 = 2'd3;
    hour0 = 4'd4;
    while (t < 143) begin
      step();
      d  = (t / 4) % 4;
      es = ef[(t / 16 - 7) * 4 + d];
      checks++;
      if (seg !== es) begin
        failures++;
        $display("FAIL invalid_seg t=%0d got=%b exp=%b", t, seg, es);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] ef [4];
    logic [6:0] es;
    int d;
    ef = '{7'h00, 7'h40, 7'h02, 7'h40};
    min0 = 4'd8;
    min1 = 3'd0;
    hour0 = 4'd6;
    hour1 = 2'd0;
    blank_lz = 1'b0;
    while (t < 175) begin
      step();
      if (t >= 160) begin
        d  = (t / 4) % 4;
        es = (d == 3 && t >= 172) ? 7'h7F : ef[d];
        checks++;
        if (seg !== es) begin
          failures++;
          $display("FAIL lz_seg t=%0d got=%b exp=%b", t, seg, es);
        end
      end
      if (t == 171) blank_lz = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    while (t < 178) step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111) begin
      failures++;
      $display("FAIL areset_an got=%b exp=1111", an);
    end
    checks++;
    if (seg !== 7'b1111111) begin
      failures++;
      $display("FAIL areset_seg got=%b exp=1111111", seg);
    end
    checks++;
    if (dp !== 1'b1) begin
      failures++;
      $display("FAIL areset_dp got=%b exp=1", dp);
    end
    @(negedge clk);
    rst = 1'b1;
    t = -1;
    repeat (8) begin
      step();
      checks++;
      if (an !== exp_an(t)) begin
        failures++;
        $display("FAIL resume_an t=%0d got=%b exp=%b", t, an, exp_an(t));
      end
      checks++;
      if (seg !== 7'h40) begin
        failures++;
        $display("FAIL resume_seg t=%0d got=%b exp=1000000", t, seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_tearing();
    test_colon();
    test_invalid();
    test_blank_lz();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Multiplexed four-digit seven-segment driver that consumes the BCD time digits (HH:MM) produced by the clock timer and renders them on a common-anode display. It scans one digit at a time, snapshots all four digits at each frame boundary to prevent tearing, blanks anodes briefly at each digit change to suppress ghosting, and blinks the colon at 1 Hz. It sits between the timer's display outputs and the board's display pins.

## Interface

- CLK_HZ, 50000000, clock frequency in Hz
- REFRESH_HZ, 250, full-frame scan rate; SLOT_CYC = CLK_HZ/(4*REFRESH_HZ) cycles per digit (≥ BLANK_CYC+1)
- BLANK_CYC, 16, anode-off cycles at the start of each digit slot
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- hour1  in  2  tens of hours, BCD 0..2
- hour0  in  4  units of hours, BCD 0..9
- min1  in  3  tens of minutes, BCD 0..5
- min0  in  4  units of minutes, BCD 0..9
- blank_lz  in  1  1 = blank hour1 digit when it is 0
- blink_en  in  1  1 = colon blinks; 0 = colon steady on
- an  out  4  anode enables, active-low; an[0]=min0 (rightmost) … an[3]=hour1
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point / colon, active-low

## Operation

- Slot counter sc counts 0..SLOT_CYC-1, then wraps to 0 and advances digit index d: 0→1→2→3→0.
- Snapshot registers (s_h1, s_h0, s_m1, s_m0) load all four inputs in the cycle where d==3 and sc==SLOT_CYC-1; the new values appear starting in the following digit-0 slot. Inputs are ignored at all other times.
- Digit select: d=0 → s_m0, 1 → s_m1, 2 → s_h0, 3 → s_h1 (zero-extended to 4 bits).
- Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Out-of-range value (digit >9, s_m1 >5, or s_h1 >2) → dash 0111111.
- Leading-zero blank: d==3, blank_lz==1, s_h1==0 → seg=1111111 (anode is still driven normally).
- Blink: counter bc counts 0..CLK_HZ/2-1; on wrap, phase toggles. colon_on = blink_en ? phase : 1.
- dp = 0 only when d==2 and colon_on==1; otherwise 1.
- an = 1111 when sc < BLANK_CYC; otherwise ~(1<<d).

## Timing

- an, seg and dp are registered. Each reflects the (sc, d, snapshot, phase) state of the previous cycle, i.e. 1-cycle latency.
- Reset (rst=0, asynchronous): an=1111, seg=1111111, dp=1, sc=0, d=0, bc=0, phase=1, snapshot=0.
- Reset asserted mid-frame immediately forces all outputs to their reset values. After release, scanning restarts at digit 0, slot cycle 0.
- After reset, the first frame shows the all-zero snapshot. The first real inputs are captured at the end of the first digit-3 slot.
- Because anodes are off for BLANK_CYC cycles per slot, each digit's lit time is SLOT_CYC-BLANK_CYC cycles per frame.
- A blink_en change takes effect on the next clock. bc keeps running regardless of blink_en.
- Input changes in the same cycle as the snapshot load are captured (they are sampled at that edge).

## Test plan

Bench parameters: CLK_HZ=64, REFRESH_HZ=4, BLANK_CYC=1 (SLOT_CYC=4, blink half-period 32 cycles).

- Reset then release, with inputs 2,3,5,9 and blank_lz=1: first frame shows an=1110/1101/1011 with seg=1000000, and digit 3 seg=1111111. The second frame shows 9,5,3,2 → seg 0010000, 0010010, 0110000, 0100100.
- Slot timing: each slot's first output cycle has an=1111, followed by 3 cycles of the selected anode. The pattern repeats every 16 cycles.
- Tearing: change min0 from 9 to 0 mid-frame → display keeps 9 until the next frame's digit-0 slot, then shows 1000000.
- Invalid input min0=4'hC, min1=6, hour1=3 → dash 0111111 on digits 0, 1 and 3.
- Colon: blink_en=1 → dp=0 during lit digit-2 cycles for 32 cycles, then dp=1 for 32 cycles. blink_en=0 → dp=0 on every lit digit-2 cycle, and dp=1 on all other digits.
- Async reset pulsed mid-slot without a clock edge → an=1111, seg=1111111 and dp=1 immediately. On release, scanning resumes from digit 0.
